mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arb_watchdog.sv | 35 +++
 rtl/mem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the mem_arbiter block.
// Holds the arbiter state encoding, data width and default watchdog limit.
// No logic; imported by every file of the block.
package mem_arb_pkg;

    localparam int XLEN                   = 32;
    localparam int TIMEOUT_CYCLES_DEFAULT = 15;
    // Watchdog counter width; limits TIMEOUT_CYCLES to 31.
    localparam int WDOG_W                 = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2
    } state_t;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Purpose : counts consecutive BUSY cycles without m_ready and flags expiry.
// Latency : expire is combinational in the cycle the count reaches the limit.
// Backpressure: none; clear (new transaction) has priority over counting.
// Ports   : clk, reset (async active-low), clear, waiting, expire.
module mem_arb_watchdog
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,    // a transaction is being loaded at this edge
    input  logic waiting,  // BUSY and m_ready low this cycle
    output logic expire
);

    // The count holds the number of earlier waiting cycles, so the limit-th
    // waiting cycle is the one where the count equals TIMEOUT_CYCLES-1.
    localparam logic [WDOG_W-1:0] LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

    logic [WDOG_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (waiting) begin
            cnt <= cnt + WDOG_W'(1);
        end
    end

    assign expire = waiting && (cnt == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Purpose : arbitrates fetch and data-stage requests onto one memory port; data side wins.
// Latency : request seen at edge N -> m_req in N+1 -> valid in N+2 at best; back-to-back chaining.
// Backpressure: waits on m_ready; stall_if/stall_dm hold requesters until their valid pulse.
// Ports   : clk, reset (async active-low); fetch if_*; data dm_*; memory m_*; stall_if,
//           stall_dm; err (sticky timeout flag).
// Option  : define MEM_ARB_TIMEOUT_EN to abort transactions after TIMEOUT_CYCLES
//           cycles without m_ready; otherwise err is 0 and BUSY waits forever.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic [XLEN-1:0] if_rdata,
    output logic            if_valid,
    input  logic            dm_read,
    input  logic            dm_write,
    input  logic [XLEN-1:0] dm_addr,
    input  logic [XLEN-1:0] dm_wdata,
    output logic [XLEN-1:0] dm_rdata,
    output logic            dm_valid,
    output logic            stall_if,
    output logic            stall_dm,
    output logic            m_req,
    output logic            m_we,
    output logic [XLEN-1:0] m_addr,
    output logic [XLEN-1:0] m_wdata,
    input  logic [XLEN-1:0] m_rdata,
    input  logic            m_ready,
    output logic            err
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 31) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT_CYCLES must lie in 1..31");
    end

    state_t          state, state_nxt;
    logic            m_req_nxt, m_we_nxt, if_valid_nxt, dm_valid_nxt;
    logic [XLEN-1:0] m_addr_nxt, m_wdata_nxt, if_rdata_nxt, dm_rdata_nxt;
    logic            dm_any, busy, done, grant_if, grant_dm;
    logic [XLEN-1:0] rsp_data;

    assign dm_any   = dm_read | dm_write;
    assign busy     = (state != IDLE);
    // A timed-out transaction completes without m_ready and returns zero.
    assign rsp_data = m_ready ? m_rdata : '0;

    assign stall_if = if_req & ~if_valid;
    assign stall_dm = dm_any & ~dm_valid;

`ifdef MEM_ARB_TIMEOUT_EN
    logic expire;

    mem_arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (grant_if | grant_dm),
        .waiting (busy & ~m_ready),
        .expire  (expire)
    );

    assign done = busy & (m_ready | expire);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err <= 1'b0;
        end else if (expire) begin
            err <= 1'b1;
        end
    end
`else
    assign done = busy & m_ready;
    assign err  = 1'b0;
`endif

    always_comb begin
        state_nxt    = state;
        m_req_nxt    = m_req;
        m_we_nxt     = m_we;
        m_addr_nxt   = m_addr;
        m_wdata_nxt  = m_wdata;
        if_rdata_nxt = if_rdata;
        dm_rdata_nxt = dm_rdata;
        if_valid_nxt = 1'b0;
        dm_valid_nxt = 1'b0;
        grant_if     = 1'b0;
        grant_dm     = 1'b0;

        case (state)
            IDLE: begin
                if (dm_any) begin
                    grant_dm = 1'b1;
                end else if (if_req) begin
                    grant_if = 1'b1;
                end
            end
            IF_BUSY: begin
                if (done) begin
                    if_valid_nxt = 1'b1;
                    if_rdata_nxt = rsp_data;
                    state_nxt    = IDLE;
                    m_req_nxt    = 1'b0;
                    m_we_nxt     = 1'b0;
                    // The fetch side is excluded from this re-arbitration.
                    grant_dm     = dm_any;
                end
            end
            DM_BUSY: begin
                if (done) begin
                    dm_valid_nxt = 1'b1;
                    // Stores leave the load data register untouched.
                    if (!m_we) begin
                        dm_rdata_nxt = rsp_data;
                    end
                    state_nxt    = IDLE;
                    m_req_nxt    = 1'b0;
                    m_we_nxt     = 1'b0;
                    grant_if     = if_req;
                end
            end
            default: begin
                state_nxt = IDLE;
                m_req_nxt = 1'b0;
                m_we_nxt  = 1'b0;
            end
        endcase

        // A grant loads the memory request, overriding the return-to-IDLE above.
        if (grant_dm) begin
            state_nxt   = DM_BUSY;
            m_req_nxt   = 1'b1;
            m_we_nxt    = dm_write;
            m_addr_nxt  = dm_addr;
            m_wdata_nxt = dm_wdata;
        end else if (grant_if) begin
            state_nxt   = IF_BUSY;
            m_req_nxt   = 1'b1;
            m_we_nxt    = 1'b0;
            m_addr_nxt  = if_addr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            if_rdata <= '0;
            dm_rdata <= '0;
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
        end else begin
            state    <= state_nxt;
            m_req    <= m_req_nxt;
            m_we     <= m_we_nxt;
            m_addr   <= m_addr_nxt;
            m_wdata  <= m_wdata_nxt;
            if_rdata <= if_rdata_nxt;
            dm_rdata <= dm_rdata_nxt;
            if_valid <= if_valid_nxt;
            dm_valid <= dm_valid_nxt;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: reset behaviour, a table of single transactions,
// hand-written multi-cycle corner cases and a randomized run against a
// transaction-level requester/memory model.
module tb_mem_arbiter;

    localparam int OP_F        = 0;
    localparam int OP_L        = 1;
    localparam int OP_S        = 2;
    localparam int NVEC        = 7;
    localparam int RAND_CYCLES = 3000;
    localparam int AGE_LIMIT   = 60;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        if_req, dm_read, dm_write, m_ready;
    logic [31:0] if_addr, dm_addr, dm_wdata, m_rdata;
    logic [31:0] if_rdata, dm_rdata, m_addr, m_wdata;
    logic        if_valid, dm_valid, stall_if, stall_dm, m_req, m_we, err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mdata;
        int          delay;
        logic        exp_we;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [NVEC];

    // Random-phase model state
    logic        if_pend, dm_pend, dm_is_wr;
    logic [31:0] if_exp_addr, dm_exp_addr, dm_exp_wdata, dm_hold;
    int          if_age, dm_age, slave_wait;
    logic [31:0] gmem [16];
    logic [31:0] smem [16];
    logic        srv_we;
    logic [31:0] srv_addr, srv_wdata;
    logic        p_req, p_ready, p_we;
    logic [31:0] p_addr, p_wdata;

    always #5 clk = ~clk;

    mem_arbiter #(
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_valid (if_valid),
        .dm_read  (dm_read),
        .dm_write (dm_write),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata),
        .dm_valid (dm_valid),
        .stall_if (stall_if),
        .stall_dm (stall_dm),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata),
        .m_ready  (m_ready),
        .err      (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if_req   = 1'b0;
        if_addr  = 32'h0;
        dm_read  = 1'b0;
        dm_write = 1'b0;
        dm_addr  = 32'h0;
        dm_wdata = 32'h0;
        m_ready  = 1'b0;
        m_rdata  = 32'h0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    function automatic logic [31:0] fetch_word(input logic [31:0] a);
        return ~a ^ 32'h0F0F_0000;
    endfunction

    // One isolated transaction from IDLE; valid must appear exactly 2+delay
    // cycles after the request is driven.
    task automatic run_vec(input int n, input vec_t v);
        if_addr  = v.addr;
        dm_addr  = v.addr;
        dm_wdata = v.wdata;
        if_req   = (v.op == OP_F);
        dm_read  = (v.op == OP_L);
        dm_write = (v.op == OP_S);
        m_ready  = 1'b0;
        m_rdata  = 32'hBAD0_BAD0;
        #1;
        check($sformatf("v%0d_stall_req", n), {stall_if, stall_dm},
              (v.op == OP_F) ? 32'd2 : 32'd1);
        step();
        for (int k = 0; k <= v.delay; k++) begin
            check($sformatf("v%0d_mreq_c%0d", n, k), m_req, 1'b1);
            check($sformatf("v%0d_maddr_c%0d", n, k), m_addr, v.addr);
            check($sformatf("v%0d_mwe_c%0d", n, k), m_we, v.exp_we);
            if (v.op == OP_S) check($sformatf("v%0d_mwdata_c%0d", n, k), m_wdata, v.wdata);
            check($sformatf("v%0d_novalid_c%0d", n, k), {if_valid, dm_valid}, 32'd0);
            check($sformatf("v%0d_stall_c%0d", n, k), {stall_if, stall_dm},
                  (v.op == OP_F) ? 32'd2 : 32'd1);
            if (k < v.delay) step();
        end
        m_ready = 1'b1;
        m_rdata = v.mdata;
        step();
        check($sformatf("v%0d_valid", n), {if_valid, dm_valid},
              (v.op == OP_F) ? 32'd2 : 32'd1);
        if (v.op == OP_F) check($sformatf("v%0d_if_rdata", n), if_rdata, v.exp_rdata);
        else              check($sformatf("v%0d_dm_rdata", n), dm_rdata, v.exp_rdata);
        check($sformatf("v%0d_mreq_after", n), m_req, 1'b0);
        check($sformatf("v%0d_stall_on_valid", n), {stall_if, stall_dm}, 32'd0);
        if_req   = 1'b0;
        dm_read  = 1'b0;
        dm_write = 1'b0;
        m_ready  = 1'b0;
        step();
        check($sformatf("v%0d_single_pulse", n), {if_valid, dm_valid}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{OP_F, 32'h0000_0100, 32'h0,         32'h0000_0013, 0, 1'b0, 32'h0000_0013};
        vecs[1] = '{OP_L, 32'h0000_2000, 32'h0,         32'hCAFE_0001, 1, 1'b0, 32'hCAFE_0001};
        vecs[2] = '{OP_S, 32'h0000_0040, 32'hDEAD_BEEF, 32'h1234_5678, 3, 1'b1, 32'hCAFE_0001};
        vecs[3] = '{OP_F, 32'h0000_0104, 32'h0,         32'hFFFF_FFFF, 2, 1'b0, 32'hFFFF_FFFF};
        vecs[4] = '{OP_L, 32'h0000_0044, 32'h0,         32'h0000_0000, 0, 1'b0, 32'h0000_0000};
        vecs[5] = '{OP_S, 32'hFFFF_FFFC, 32'h0,         32'hAAAA_5555, 0, 1'b1, 32'h0000_0000};
        vecs[6] = '{OP_L, 32'hFFFF_FFFC, 32'h0,         32'h8000_0000, 3, 1'b0, 32'h8000_0000};

        // ---- Asynchronous reset and first arbitration after release ----
        clear_inputs();
        dm_read = 1'b1;  dm_addr = 32'h44;
        if_req  = 1'b1;  if_addr = 32'h100;
        m_ready = 1'b1;  m_rdata = 32'h77;
        #2 reset = 1'b0;
        #1;
        check("rst_mreq", m_req, 1'b0);
        check("rst_mwe", m_we, 1'b0);
        check("rst_valids", {if_valid, dm_valid}, 32'd0);
        check("rst_err", err, 1'b0);
        check("rst_maddr", m_addr, 32'h0);
        check("rst_mwdata", m_wdata, 32'h0);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_dm_rdata", dm_rdata, 32'h0);
        check("rst_stalls", {stall_if, stall_dm}, 32'd3);
        step();
        step();
        check("rst_held_mreq", m_req, 1'b0);
        reset = 1'b1;
        step();
        check("first_arb_mreq", m_req, 1'b1);
        check("first_arb_dm_wins", m_addr, 32'h44);
        step();
        check("first_dm_valid", dm_valid, 1'b1);
        check("first_dm_rdata", dm_rdata, 32'h77);
        check("chain_to_if", m_addr, 32'h100);
        dm_read = 1'b0;
        step();
        check("first_if_valid", if_valid, 1'b1);
        check("first_if_rdata", if_rdata, 32'h77);
        clear_inputs();
        step();
        check("first_quiet", {m_req, if_valid, dm_valid}, 32'd0);

        // ---- Table of isolated transactions ----
        do_reset();
        for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);

        // ---- Stuck memory: timeout or indefinite wait ----
        dm_read = 1'b1;
        dm_addr = 32'h80;
        m_ready = 1'b0;
        m_rdata = 32'hFFFF_FFFF;
        step();
`ifdef MEM_ARB_TIMEOUT_EN
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("to_mreq_c%0d", k), m_req, 1'b1);
            check($sformatf("to_novalid_c%0d", k), dm_valid, 1'b0);
            check($sformatf("to_noerr_c%0d", k), err, 1'b0);
            step();
        end
        check("to_mreq_drop", m_req, 1'b0);
        check("to_dm_valid", dm_valid, 1'b1);
        check("to_dm_rdata", dm_rdata, 32'h0);
        check("to_err", err, 1'b1);
        dm_read = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("to_err_sticky_%0d", k), err, 1'b1);
            check($sformatf("to_quiet_%0d", k), {m_req, dm_valid}, 32'd0);
        end
`else
        for (int k = 1; k <= 20; k++) begin
            check($sformatf("stuck_mreq_c%0d", k), m_req, 1'b1);
            check($sformatf("stuck_novalid_c%0d", k), dm_valid, 1'b0);
            step();
        end
        check("stuck_err", err, 1'b0);
        m_ready = 1'b1;
        m_rdata = 32'h0BAD_CAFE;
        step();
        check("stuck_dm_valid", dm_valid, 1'b1);
        check("stuck_dm_rdata", dm_rdata, 32'h0BAD_CAFE);
        dm_read = 1'b0;
        m_ready = 1'b0;
        step();
`endif

        // ---- Simultaneous requests: data first, fetch with no gap ----
        clear_inputs();
        step();
        if_req  = 1'b1;  if_addr = 32'h100;
        dm_read = 1'b1;  dm_addr = 32'h2000;
        m_ready = 1'b1;  m_rdata = 32'h1111_1111;
        step();
        check("sim_maddr_dm", m_addr, 32'h2000);
        check("sim_mwe_dm", m_we, 1'b0);
        m_rdata = 32'h2222_2222;
        step();
        check("sim_dm_valid", dm_valid, 1'b1);
        check("sim_dm_rdata", dm_rdata, 32'h2222_2222);
        check("sim_if_waiting", if_valid, 1'b0);
        check("sim_no_gap_mreq", m_req, 1'b1);
        check("sim_no_gap_maddr", m_addr, 32'h100);
        check("sim_stall_if", stall_if, 1'b1);
        dm_read = 1'b0;
        m_rdata = 32'h3333_3333;
        step();
        check("sim_if_valid", if_valid, 1'b1);
        check("sim_if_rdata", if_rdata, 32'h3333_3333);
        check("sim_idle_mreq", m_req, 1'b0);
        clear_inputs();
        step();

        // ---- Reset in the 2nd cycle of a fetch discards it ----
        if_req  = 1'b1;
        if_addr = 32'h200;
        m_ready = 1'b0;
        step();
        check("rmid_c1_mreq", m_req, 1'b1);
        step();
        check("rmid_c2_mreq", m_req, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("rmid_mreq_async", m_req, 1'b0);
        m_ready = 1'b1;
        m_rdata = 32'h9999_9999;
        step();
        if_req = 1'b0;
        reset  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("rmid_no_valid_%0d", k), if_valid, 1'b0);
            check($sformatf("rmid_idle_%0d", k), m_req, 1'b0);
        end
        check("rmid_if_rdata", if_rdata, 32'h0);
        check("rmid_err", err, 1'b0);
        if_req  = 1'b1;
        if_addr = 32'h300;
        m_rdata = 32'h55;
        step();
        check("rmid_new_maddr", m_addr, 32'h300);
        step();
        check("rmid_new_valid", if_valid, 1'b1);
        check("rmid_new_rdata", if_rdata, 32'h55);
        clear_inputs();

        // ---- Randomized traffic against the requester/memory model ----
        do_reset();
        if_pend = 1'b0;  dm_pend = 1'b0;  dm_is_wr = 1'b0;
        if_age = 0;  dm_age = 0;  slave_wait = 0;
        if_exp_addr = 32'h0;  dm_exp_addr = 32'h0;  dm_exp_wdata = 32'h0;
        dm_hold = 32'h0;
        srv_we = 1'b0;  srv_addr = 32'h0;  srv_wdata = 32'h0;
        p_req = 1'b0;  p_ready = 1'b0;  p_we = 1'b0;  p_addr = 32'h0;  p_wdata = 32'h0;
        for (int i = 0; i < 16; i++) begin
            gmem[i] = 32'h5A5A_0000 ^ (32'h0101_0101 * 32'(i));
            smem[i] = gmem[i];
        end

        for (int cyc = 0; cyc < RAND_CYCLES; cyc++) begin
            step();
            if (if_valid) begin
                if (!if_pend) begin
                    check("rnd_spurious_if_valid", if_valid, 1'b0);
                end else begin
                    check("rnd_if_rdata", if_rdata, fetch_word(if_exp_addr));
                    check("rnd_if_served_addr", srv_addr, if_exp_addr);
                    check("rnd_if_served_we", srv_we, 1'b0);
                    if_pend = 1'b0;
                end
            end
            if (dm_valid) begin
                if (!dm_pend) begin
                    check("rnd_spurious_dm_valid", dm_valid, 1'b0);
                end else begin
                    check("rnd_dm_served_addr", srv_addr, dm_exp_addr);
                    check("rnd_dm_served_we", srv_we, dm_is_wr);
                    if (dm_is_wr) begin
                        check("rnd_dm_served_wdata", srv_wdata, dm_exp_wdata);
                        gmem[dm_exp_addr[5:2]] = dm_exp_wdata;
                    end else begin
                        dm_hold = gmem[dm_exp_addr[5:2]];
                    end
                    dm_pend = 1'b0;
                end
            end
            check("rnd_dm_rdata_hold", dm_rdata, dm_hold);
            check("rnd_err", err, 1'b0);
            if (p_req && !p_ready) begin
                check("rnd_hold_mreq", m_req, 1'b1);
                check("rnd_hold_maddr", m_addr, p_addr);
                check("rnd_hold_mwe", m_we, p_we);
                check("rnd_hold_mwdata", m_wdata, p_wdata);
                check("rnd_no_valid_while_wait", {if_valid, dm_valid}, 32'd0);
            end
            if (m_req && !m_addr[15]) check("rnd_fetch_we", m_we, 1'b0);

            if (if_pend) begin
                if_age++;
                if (if_age > AGE_LIMIT) begin
                    checks++;
                    errors++;
                    $display("FAIL rnd_if_timeout: pending %0d cycles, limit %0d", if_age, AGE_LIMIT);
                    if_pend = 1'b0;
                end
            end
            if (dm_pend) begin
                dm_age++;
                if (dm_age > AGE_LIMIT) begin
                    checks++;
                    errors++;
                    $display("FAIL rnd_dm_timeout: pending %0d cycles, limit %0d", dm_age, AGE_LIMIT);
                    dm_pend = 1'b0;
                end
            end

            if (!if_pend && ($urandom_range(0, 3) != 0)) begin
                if_pend     = 1'b1;
                if_age      = 0;
                if_exp_addr = 32'h1000 + 32'($urandom_range(0, 1023)) * 32'd4;
            end
            if (!dm_pend && ($urandom_range(0, 2) == 0)) begin
                dm_pend      = 1'b1;
                dm_age       = 0;
                dm_is_wr     = ($urandom_range(0, 1) == 1);
                dm_exp_addr  = 32'h8000 + 32'($urandom_range(0, 15)) * 32'd4;
                dm_exp_wdata = $urandom;
            end
            if_req   = if_pend;
            if_addr  = if_pend ? if_exp_addr : $urandom;
            dm_read  = dm_pend & ~dm_is_wr;
            dm_write = dm_pend & dm_is_wr;
            dm_addr  = dm_pend ? dm_exp_addr : $urandom;
            dm_wdata = dm_pend ? dm_exp_wdata : $urandom;

            // Memory: random wait of at most two cycles per transaction.
            if (m_req) begin
                m_ready = (slave_wait >= 2) || ($urandom_range(0, 1) == 1);
                if (m_ready) begin
                    m_rdata    = m_addr[15] ? smem[m_addr[5:2]] : fetch_word(m_addr);
                    srv_addr   = m_addr;
                    srv_we     = m_we;
                    srv_wdata  = m_wdata;
                    if (m_we) smem[m_addr[5:2]] = m_wdata;
                    slave_wait = 0;
                end else begin
                    m_rdata = $urandom;
                    slave_wait++;
                end
            end else begin
                m_ready    = 1'b0;
                m_rdata    = $urandom;
                slave_wait = 0;
            end

            #1;
            check("rnd_stall_if", stall_if, if_req & ~if_valid);
            check("rnd_stall_dm", stall_dm, (dm_read | dm_write) & ~dm_valid);
            p_req   = m_req;
            p_ready = m_ready;
            p_we    = m_we;
            p_addr  = m_addr;
            p_wdata = m_wdata;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
